exec_unit: RTL and testbench

Parametrised execution unit for the out-of-order core. It accepts one issued instruction per cycle from the ALU reservation station and computes integer, branch and jump results. When M-extension support is enabled it also computes RV32M multiply, divide and remainder. Results are broadcast once, with their ROB tag, on the common data bus (CDB) after a registered output stage.

---
 rtl/exec_unit_pkg.sv | 29 ++
 rtl/exec_unit_divider.sv | 103 ++++++++++
 rtl/exec_unit.sv | 190 +++++++++++++++++++
 tb/tb_exec_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_unit_pkg.sv
// Shared definitions for the execution unit: operation encoding, data types
// and the divider FSM state type.
package exec_unit_pkg;

  localparam int DEFAULT_XLEN = 32;

  typedef logic [DEFAULT_XLEN-1:0] data_t;
  typedef logic [DEFAULT_XLEN-1:0] addr_t;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // M-extension ops follow ANDI so the base encodings keep their values.
  typedef enum logic [5:0] {
    OP_ENUM_LUI, OP_ENUM_AUIPC, OP_ENUM_JAL, OP_ENUM_JALR,
    OP_ENUM_BEQ, OP_ENUM_BNE, OP_ENUM_BLT, OP_ENUM_BGE, OP_ENUM_BLTU, OP_ENUM_BGEU,
    OP_ENUM_ADD, OP_ENUM_SUB, OP_ENUM_SLL, OP_ENUM_SLT, OP_ENUM_SLTU,
    OP_ENUM_XOR, OP_ENUM_SRL, OP_ENUM_SRA, OP_ENUM_OR, OP_ENUM_AND,
    OP_ENUM_ADDI, OP_ENUM_SLTI, OP_ENUM_SLTIU, OP_ENUM_XORI, OP_ENUM_ORI,
    OP_ENUM_SLLI, OP_ENUM_SRLI, OP_ENUM_SRAI, OP_ENUM_ANDI,
    OP_ENUM_MUL, OP_ENUM_MULH, OP_ENUM_MULHSU, OP_ENUM_MULHU,
    OP_ENUM_DIV, OP_ENUM_DIVU, OP_ENUM_REM, OP_ENUM_REMU
  } op_enum_t;

  localparam int OP_ENUM_TYPE_W = $bits(op_enum_t);

  typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_DONE} div_state_t;

endpackage

// File: rtl/exec_unit_divider.sv
// Iterative restoring divider: one quotient bit per cycle on absolute values,
// sign fix-up in DIV_DONE; zero divisor and MIN/-1 skip straight to DIV_DONE.
module exec_divider
  import exec_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  logic            i_flush,
  input  logic            i_start,
  input  logic            i_signed,
  input  logic            i_rem,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output div_state_t      o_state
);

  localparam int CW = $clog2(XLEN);

  div_state_t      r_state, w_next;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_quot, r_rem, r_dvs, r_spec_res;
  logic            r_special, r_neg_q, r_neg_r, r_is_rem;

  logic [XLEN-1:0] w_min, w_abs_a, w_abs_b, w_spec_res, w_q, w_r;
  logic            w_zero, w_ovf;
  logic [XLEN:0]   w_shift, w_diff;

  assign w_min   = {1'b1, {(XLEN-1){1'b0}}};
  assign w_zero  = (i_divisor == '0);
  assign w_ovf   = i_signed && (i_dividend == w_min) && (i_divisor == '1);
  assign w_abs_a = (i_signed && i_dividend[XLEN-1]) ? -i_dividend : i_dividend;
  assign w_abs_b = (i_signed && i_divisor[XLEN-1])  ? -i_divisor  : i_divisor;
  assign w_spec_res = w_zero ? (i_rem ? i_dividend : '1) : (i_rem ? '0 : w_min);

  // Partial remainder needs one extra bit: 2*rem+1 can exceed XLEN bits.
  assign w_shift = {r_rem, r_quot[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (i_start) w_next = (w_zero || w_ovf) ? DIV_DONE : DIV_RUN;
      DIV_RUN:  if (r_count == '0) w_next = DIV_DONE;
      DIV_DONE: w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_state <= IDLE;
    else if (i_flush) r_state <= IDLE;
    else if (i_en)    r_state <= w_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count    <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_dvs      <= '0;
      r_spec_res <= '0;
      r_special  <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_is_rem   <= 1'b0;
    end else if (i_flush) begin
      r_count <= '0;
    end else if (i_en) begin
      if (r_state == IDLE && i_start) begin
        r_special  <= w_zero || w_ovf;
        r_spec_res <= w_spec_res;
        r_quot     <= w_abs_a;
        r_rem      <= '0;
        r_dvs      <= w_abs_b;
        r_neg_q    <= i_signed && (i_dividend[XLEN-1] ^ i_divisor[XLEN-1]);
        r_neg_r    <= i_signed && i_dividend[XLEN-1];
        r_is_rem   <= i_rem;
        r_count    <= CW'(XLEN-1);
      end else if (r_state == DIV_RUN) begin
        if (!w_diff[XLEN]) begin
          r_rem  <= w_diff[XLEN-1:0];
          r_quot <= {r_quot[XLEN-2:0], 1'b1};
        end else begin
          r_rem  <= w_shift[XLEN-1:0];
          r_quot <= {r_quot[XLEN-2:0], 1'b0};
        end
        if (r_count != '0) r_count <= r_count - 1'b1;
      end
    end
  end

  assign w_q      = r_neg_q ? -r_quot : r_quot;
  assign w_r      = r_neg_r ? -r_rem : r_rem;
  assign o_result = r_special ? r_spec_res : (r_is_rem ? w_r : w_q);
  assign o_done   = (r_state == DIV_DONE);
  assign o_state  = r_state;

endmodule

// File: rtl/exec_unit.sv
// Execution unit: single-cycle base ALU, two-stage multiplier and iterative
// divider feeding one registered CDB output.
module exec_unit
  import exec_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int EN_M  = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_enum_t         in_op,
  input  logic [XLEN-1:0]  in_v1,
  input  logic [XLEN-1:0]  in_v2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [XLEN-1:0]  out_result,
  output logic             out_jump,
  output logic [XLEN-1:0]  out_target
);

  localparam int SHW = $clog2(XLEN);

  // Handshake: an op is taken on a rising clk_in when in_valid && in_ready
  // and no flush; in_ready never depends on in_valid.
  logic              w_accept, w_is_mul, w_is_div, w_div_done, w_br_taken;
  logic              w_mul_sa, w_mul_sb;
  logic [SHW-1:0]    w_sh_r, w_sh_i;
  logic [XLEN-1:0]   w_res, w_target, w_jalr, w_div_result;
  logic              w_jump;
  logic [2*XLEN-1:0] w_mul_a, w_mul_b, w_prod;
  div_state_t        w_div_state;

  logic              r_mul_valid, r_mul_hi;
  logic [2*XLEN-1:0] r_prod;
  logic [TAG_W-1:0]  r_mul_tag, r_div_tag, r_out_tag;
  logic              r_out_valid, r_out_jump;
  logic [XLEN-1:0]   r_out_result, r_out_target;

  assign w_is_mul = (EN_M != 0) &&
                    (in_op inside {OP_ENUM_MUL, OP_ENUM_MULH, OP_ENUM_MULHSU, OP_ENUM_MULHU});
  assign w_is_div = (EN_M != 0) &&
                    (in_op inside {OP_ENUM_DIV, OP_ENUM_DIVU, OP_ENUM_REM, OP_ENUM_REMU});
  assign in_ready = rst_in && rdy_in && (w_div_state == IDLE) && !r_mul_valid;
  assign w_accept = in_valid && in_ready && !flush_in;

  assign w_sh_r = in_v2[SHW-1:0];
  assign w_sh_i = in_imm[SHW-1:0];
  assign w_jalr = in_v1 + in_imm;

  always_comb begin
    w_br_taken = 1'b0;
    case (in_op)
      OP_ENUM_BEQ:  w_br_taken = (in_v1 == in_v2);
      OP_ENUM_BNE:  w_br_taken = (in_v1 != in_v2);
      OP_ENUM_BLT:  w_br_taken = ($signed(in_v1) < $signed(in_v2));
      OP_ENUM_BGE:  w_br_taken = ($signed(in_v1) >= $signed(in_v2));
      OP_ENUM_BLTU: w_br_taken = (in_v1 < in_v2);
      OP_ENUM_BGEU: w_br_taken = (in_v1 >= in_v2);
      default:      w_br_taken = 1'b0;
    endcase
  end

  // Non-control ops report target 0; illegal ops fall through to result 0.
  always_comb begin
    w_res    = '0;
    w_jump   = 1'b0;
    w_target = '0;
    case (in_op)
      OP_ENUM_LUI:   w_res = in_imm;
      OP_ENUM_AUIPC: w_res = in_pc + in_imm;
      OP_ENUM_JAL:   begin w_res = in_pc + XLEN'(4); w_jump = 1'b1; w_target = in_pc + in_imm; end
      OP_ENUM_JALR:  begin w_res = in_pc + XLEN'(4); w_jump = 1'b1; w_target = {w_jalr[XLEN-1:1], 1'b0}; end
      OP_ENUM_BEQ, OP_ENUM_BNE, OP_ENUM_BLT, OP_ENUM_BGE, OP_ENUM_BLTU, OP_ENUM_BGEU: begin
        w_res    = {{(XLEN-1){1'b0}}, w_br_taken};
        w_jump   = w_br_taken;
        w_target = in_pc + in_imm;
      end
      OP_ENUM_ADD:   w_res = in_v1 + in_v2;
      OP_ENUM_SUB:   w_res = in_v1 - in_v2;
      OP_ENUM_SLL:   w_res = in_v1 << w_sh_r;
      OP_ENUM_SLT:   w_res = {{(XLEN-1){1'b0}}, ($signed(in_v1) < $signed(in_v2))};
      OP_ENUM_SLTU:  w_res = {{(XLEN-1){1'b0}}, (in_v1 < in_v2)};
      OP_ENUM_XOR:   w_res = in_v1 ^ in_v2;
      OP_ENUM_SRL:   w_res = in_v1 >> w_sh_r;
      OP_ENUM_SRA:   w_res = $signed(in_v1) >>> w_sh_r;
      OP_ENUM_OR:    w_res = in_v1 | in_v2;
      OP_ENUM_AND:   w_res = in_v1 & in_v2;
      OP_ENUM_ADDI:  w_res = in_v1 + in_imm;
      OP_ENUM_SLTI:  w_res = {{(XLEN-1){1'b0}}, ($signed(in_v1) < $signed(in_imm))};
      OP_ENUM_SLTIU: w_res = {{(XLEN-1){1'b0}}, (in_v1 < in_imm)};
      OP_ENUM_XORI:  w_res = in_v1 ^ in_imm;
      OP_ENUM_ORI:   w_res = in_v1 | in_imm;
      OP_ENUM_SLLI:  w_res = in_v1 << w_sh_i;
      OP_ENUM_SRLI:  w_res = in_v1 >> w_sh_i;
      OP_ENUM_SRAI:  w_res = $signed(in_v1) >>> w_sh_i;
      OP_ENUM_ANDI:  w_res = in_v1 & in_imm;
      default:       w_res = '0;
    endcase
  end

  assign w_mul_sa = (in_op == OP_ENUM_MULH) || (in_op == OP_ENUM_MULHSU) || (in_op == OP_ENUM_MUL);
  assign w_mul_sb = (in_op == OP_ENUM_MULH) || (in_op == OP_ENUM_MUL);
  assign w_mul_a  = {{XLEN{w_mul_sa & in_v1[XLEN-1]}}, in_v1};
  assign w_mul_b  = {{XLEN{w_mul_sb & in_v2[XLEN-1]}}, in_v2};
  assign w_prod   = w_mul_a * w_mul_b;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_mul_valid <= 1'b0;
      r_mul_hi    <= 1'b0;
      r_prod      <= '0;
      r_mul_tag   <= '0;
      r_div_tag   <= '0;
    end else if (flush_in) begin
      r_mul_valid <= 1'b0;
    end else if (rdy_in) begin
      r_mul_valid <= w_accept && w_is_mul;
      if (w_accept && w_is_mul) begin
        r_prod    <= w_prod;
        r_mul_hi  <= (in_op != OP_ENUM_MUL);
        r_mul_tag <= in_tag;
      end
      if (w_accept && w_is_div) r_div_tag <= in_tag;
    end
  end

  exec_divider #(.XLEN(XLEN)) u_div (
    .i_clk      (clk_in),
    .i_rst_n    (rst_in),
    .i_en       (rdy_in),
    .i_flush    (flush_in),
    .i_start    (w_accept && w_is_div),
    .i_signed   ((in_op == OP_ENUM_DIV) || (in_op == OP_ENUM_REM)),
    .i_rem      ((in_op == OP_ENUM_REM) || (in_op == OP_ENUM_REMU)),
    .i_dividend (in_v1),
    .i_divisor  (in_v2),
    .o_done     (w_div_done),
    .o_result   (w_div_result),
    .o_state    (w_div_state)
  );

  // in_ready gating guarantees at most one source is ready each cycle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_out_valid  <= 1'b0;
      r_out_tag    <= '0;
      r_out_result <= '0;
      r_out_jump   <= 1'b0;
      r_out_target <= '0;
    end else if (flush_in) begin
      r_out_valid <= 1'b0;
    end else if (rdy_in) begin
      r_out_valid <= 1'b0;
      if (r_mul_valid) begin
        r_out_valid  <= 1'b1;
        r_out_tag    <= r_mul_tag;
        r_out_result <= r_mul_hi ? r_prod[2*XLEN-1:XLEN] : r_prod[XLEN-1:0];
        r_out_jump   <= 1'b0;
        r_out_target <= '0;
      end else if (w_div_done) begin
        r_out_valid  <= 1'b1;
        r_out_tag    <= r_div_tag;
        r_out_result <= w_div_result;
        r_out_jump   <= 1'b0;
        r_out_target <= '0;
      end else if (w_accept && !w_is_mul && !w_is_div) begin
        r_out_valid  <= 1'b1;
        r_out_tag    <= in_tag;
        r_out_result <= w_res;
        r_out_jump   <= w_jump;
        r_out_target <= w_target;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_tag    = r_out_tag;
  assign out_result = r_out_result;
  assign out_jump   = r_out_jump;
  assign out_target = r_out_target;

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: per-scenario tasks push expected CDB
// results; a negedge monitor pops and compares every out_valid pulse.
module tb_exec_unit;
  import exec_unit_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;
  localparam int EW    = TAG_W + XLEN + 1 + XLEN;

  logic             clk_in = 1'b0;
  logic             rst_in, rdy_in, flush_in, in_valid;
  logic             in_ready;
  op_enum_t         in_op;
  logic [XLEN-1:0]  in_v1, in_v2, in_imm, in_pc;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_jump;
  logic [TAG_W-1:0] out_tag;
  logic [XLEN-1:0]  out_result, out_target;

  exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .EN_M(1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_v1(in_v1), .in_v2(in_v2), .in_imm(in_imm), .in_pc(in_pc), .in_tag(in_tag),
    .out_valid(out_valid), .out_tag(out_tag), .out_result(out_result),
    .out_jump(out_jump), .out_target(out_target)
  );

  // clock / cycle counter
  always #5 clk_in = ~clk_in;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int            out_cyc_q[$];
  int            checks = 0;
  int            fails  = 0;

  function automatic logic [EW-1:0] mk(input logic [TAG_W-1:0] t, input logic [XLEN-1:0] r,
                                       input logic j, input logic [XLEN-1:0] tg);
    return {t, r, j, tg};
  endfunction

  always @(negedge clk_in) begin
    logic [EW-1:0] exp_v;
    if (rst_in && out_valid) begin
      out_cyc_q.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL cdb_unexpected: got tag=%0h result=%h, required no output", out_tag, out_result);
      end else begin
        exp_v = exp_q.pop_front();
        if ({out_tag, out_result, out_jump, out_target} !== exp_v)
          begin
            fails++;
            $display("FAIL cdb_result: got tag=%0h res=%h jump=%b tgt=%h, required tag=%0h res=%h jump=%b tgt=%h",
                     out_tag, out_result, out_jump, out_target,
                     exp_v[EW-1 -: TAG_W], exp_v[2*XLEN -: XLEN], exp_v[XLEN], exp_v[XLEN-1:0]);
          end
      end
    end
  end

  // driver tasks
  task automatic send(input op_enum_t op, input logic [XLEN-1:0] v1, input logic [XLEN-1:0] v2,
                      input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc,
                      input logic [TAG_W-1:0] tag, output int acc);
    int n = 0;
    while (!in_ready && n < 100) begin @(posedge clk_in); #1; n++; end
    checks++;
    if (!in_ready) begin
      fails++;
      $display("FAIL issue_timeout: in_ready=%b, required 1 within 100 cycles", in_ready);
    end
    in_valid = 1'b1; in_op = op; in_v1 = v1; in_v2 = v2; in_imm = imm; in_pc = pc; in_tag = tag;
    acc = cyc;
    @(posedge clk_in); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_cdb(input int n);
    int k = 0;
    while (out_cyc_q.size() < n && k < 200) begin @(posedge clk_in); #1; k++; end
    checks++;
    if (out_cyc_q.size() < n) begin
      fails++;
      $display("FAIL cdb_timeout: got %0d outputs, required %0d", out_cyc_q.size(), n);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk_in); #1; end
  endtask

  task automatic test_reset;
    idle(2);
    checks += 6;
    if (out_valid !== 1'b0)  begin fails++; $display("FAIL rst_valid: got %b, required 0", out_valid); end
    if (out_tag !== '0)      begin fails++; $display("FAIL rst_tag: got %h, required 0", out_tag); end
    if (out_result !== '0)   begin fails++; $display("FAIL rst_result: got %h, required 0", out_result); end
    if (out_jump !== 1'b0)   begin fails++; $display("FAIL rst_jump: got %b, required 0", out_jump); end
    if (out_target !== '0)   begin fails++; $display("FAIL rst_target: got %h, required 0", out_target); end
    if (in_ready !== 1'b0)   begin fails++; $display("FAIL rst_ready: got %b, required 0", in_ready); end
    rst_in = 1'b1;
    idle(1);
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL post_rst_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_back_to_back;
    int a1, a2;
    out_cyc_q.delete();
    exp_q.push_back(mk(4'h1, 32'h7FFF_FFDF, 1'b0, 32'h0));
    exp_q.push_back(mk(4'h2, 32'hC000_0000, 1'b0, 32'h0));
    send(OP_ENUM_SUB, 32'h8000_0000, 32'h21, 32'h0, 32'h0, 4'h1, a1);
    send(OP_ENUM_SRA, 32'h8000_0000, 32'h21, 32'h0, 32'h0, 4'h2, a2);
    wait_cdb(2);
    checks += 2;
    if (a2 !== a1 + 1) begin fails++; $display("FAIL b2b_issue: got gap %0d, required 1", a2 - a1); end
    if (out_cyc_q.size() < 2 || out_cyc_q[0] !== a1 + 1 || out_cyc_q[1] !== a1 + 2) begin
      fails++;
      $display("FAIL b2b_latency: got %0d outputs first at +%0d, required +1 and +2",
               out_cyc_q.size(), (out_cyc_q.size() > 0) ? out_cyc_q[0] - a1 : -1);
    end
  endtask

  task automatic test_branch_alu;
    int a;
    out_cyc_q.delete();
    exp_q.push_back(mk(4'h3, 32'h1, 1'b1, 32'hF8));
    send(OP_ENUM_BLTU, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 32'h100, 4'h3, a);
    exp_q.push_back(mk(4'h4, 32'h204, 1'b1, 32'h1002));
    send(OP_ENUM_JALR, 32'h1001, 32'h0, 32'h2, 32'h200, 4'h4, a);
    exp_q.push_back(mk(4'h5, 32'h0, 1'b0, 32'h50));
    send(OP_ENUM_BEQ, 32'h5, 32'h6, 32'h10, 32'h40, 4'h5, a);
    exp_q.push_back(mk(4'h6, 32'h1, 1'b1, 32'h320));
    send(OP_ENUM_BLT, 32'hFFFF_FFFF, 32'h1, 32'h20, 32'h300, 4'h6, a);
    exp_q.push_back(mk(4'h7, 32'h1, 1'b0, 32'h0));
    send(OP_ENUM_SLTI, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0, 4'h7, a);
    exp_q.push_back(mk(4'h8, 32'hF800_0001, 1'b0, 32'h0));
    send(OP_ENUM_SRAI, 32'h8000_0010, 32'h0, 32'h24, 32'h0, 4'h8, a);
    exp_q.push_back(mk(4'h9, 32'h1234_5000, 1'b0, 32'h0));
    send(OP_ENUM_LUI, 32'h0, 32'h0, 32'h1234_5000, 32'h0, 4'h9, a);
    exp_q.push_back(mk(4'hA, 32'h3000, 1'b0, 32'h0));
    send(OP_ENUM_AUIPC, 32'h0, 32'h0, 32'h2000, 32'h1000, 4'hA, a);
    exp_q.push_back(mk(4'hB, 32'h8000_0000, 1'b0, 32'h0));
    send(OP_ENUM_SLL, 32'h1, 32'h3F, 32'h0, 32'h0, 4'hB, a);
    wait_cdb(9);
  endtask

  task automatic test_mul;
    op_enum_t ops[4] = '{OP_ENUM_MULH, OP_ENUM_MULHU, OP_ENUM_MUL, OP_ENUM_MULHSU};
    logic [XLEN-1:0] va[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h3, 32'hFFFF_FFFF};
    logic [XLEN-1:0] vb[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5, 32'h2};
    logic [XLEN-1:0] er[4] = '{32'h0, 32'hFFFF_FFFE, 32'hF, 32'hFFFF_FFFF};
    int a;
    for (int i = 0; i < 4; i++) begin
      out_cyc_q.delete();
      exp_q.push_back(mk(TAG_W'(i), er[i], 1'b0, 32'h0));
      send(ops[i], va[i], vb[i], 32'h0, 32'h0, TAG_W'(i), a);
      checks++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL mul_ready_n1: got %b, required 0", in_ready); end
      idle(1);
      checks++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL mul_ready_n2: got %b, required 1", in_ready); end
      wait_cdb(1);
      checks++;
      if (out_cyc_q.size() < 1 || out_cyc_q[0] !== a + 2) begin
        fails++;
        $display("FAIL mul_latency: got +%0d, required +2", (out_cyc_q.size() > 0) ? out_cyc_q[0] - a : -1);
      end
    end
  endtask

  task automatic test_div;
    op_enum_t ops[8] = '{OP_ENUM_DIV, OP_ENUM_REM, OP_ENUM_DIVU, OP_ENUM_REMU,
                         OP_ENUM_DIVU, OP_ENUM_REM, OP_ENUM_DIV, OP_ENUM_REMU};
    logic [XLEN-1:0] va[8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'h1234, 32'h8000_0000, 32'h8000_0000, 32'h1234};
    logic [XLEN-1:0] vb[8] = '{32'h2, 32'h2, 32'h3, 32'h8000_0000,
                               32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    logic [XLEN-1:0] er[8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h5555_5555, 32'h7FFF_FFFF,
                               32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h1234};
    int lat[8] = '{34, 34, 34, 34, 2, 2, 2, 2};
    int a;
    logic bad;
    for (int i = 0; i < 8; i++) begin
      out_cyc_q.delete();
      exp_q.push_back(mk(TAG_W'(i + 4), er[i], 1'b0, 32'h0));
      send(ops[i], va[i], vb[i], 32'h0, 32'h0, TAG_W'(i + 4), a);
      bad = 1'b0;
      for (int c = 1; c < lat[i]; c++) begin
        if (in_ready !== 1'b0) bad = 1'b1;
        idle(1);
      end
      checks++;
      if (bad) begin fails++; $display("FAIL div_ready_low: got in_ready=1 during op %0d, required 0", i); end
      wait_cdb(1);
      checks++;
      if (out_cyc_q.size() < 1 || out_cyc_q[0] !== a + lat[i]) begin
        fails++;
        $display("FAIL div_latency: op %0d got +%0d, required +%0d", i,
                 (out_cyc_q.size() > 0) ? out_cyc_q[0] - a : -1, lat[i]);
      end
    end
  endtask

  task automatic test_flush;
    int a;
    out_cyc_q.delete();
    send(OP_ENUM_DIV, 32'd100, 32'd7, 32'h0, 32'h0, 4'hC, a);
    idle(10);
    flush_in = 1'b1;
    idle(1);
    flush_in = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_ready: got %b, required 1", in_ready); end
    exp_q.push_back(mk(4'hD, 32'h7, 1'b0, 32'h0));
    send(OP_ENUM_ADD, 32'h3, 32'h4, 32'h0, 32'h0, 4'hD, a);
    wait_cdb(1);
    checks++;
    if (out_cyc_q.size() < 1 || out_cyc_q[0] !== a + 1) begin
      fails++;
      $display("FAIL flush_add_latency: got +%0d, required +1", (out_cyc_q.size() > 0) ? out_cyc_q[0] - a : -1);
    end
    idle(40);
    checks++;
    if (out_cyc_q.size() !== 1) begin
      fails++;
      $display("FAIL flush_no_div_output: got %0d outputs, required 1", out_cyc_q.size());
    end
  endtask

  task automatic test_stall;
    int a;
    out_cyc_q.delete();
    exp_q.push_back(mk(4'hE, 32'd14, 1'b0, 32'h0));
    send(OP_ENUM_DIVU, 32'd100, 32'd7, 32'h0, 32'h0, 4'hE, a);
    idle(9);
    rdy_in = 1'b0;
    idle(5);
    rdy_in = 1'b1;
    wait_cdb(1);
    checks++;
    if (out_cyc_q.size() < 1 || out_cyc_q[0] !== a + 39) begin
      fails++;
      $display("FAIL stall_latency: got +%0d, required +39", (out_cyc_q.size() > 0) ? out_cyc_q[0] - a : -1);
    end
  endtask

  task automatic test_reset_abort;
    int a;
    out_cyc_q.delete();
    send(OP_ENUM_DIV, 32'd50, 32'd3, 32'h0, 32'h0, 4'hF, a);
    idle(5);
    rst_in = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL abort_state: got in_ready=%b out_valid=%b, required 0 0", in_ready, out_valid);
    end
    idle(2);
    rst_in = 1'b1;
    idle(40);
    checks++;
    if (out_cyc_q.size() !== 0) begin
      fails++;
      $display("FAIL abort_no_output: got %0d outputs, required 0", out_cyc_q.size());
    end
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; in_valid = 1'b0;
    in_op = OP_ENUM_ADD; in_v1 = '0; in_v2 = '0; in_imm = '0; in_pc = '0; in_tag = '0;
    @(posedge clk_in); #1;
    test_reset;
    test_back_to_back;
    test_branch_alu;
    test_mul;
    test_div;
    test_flush;
    test_stall;
    test_reset_abort;
    checks++;
    if (exp_q.size() !== 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
